// File: rtl/div_unit.sv
// Multi-cycle 32-bit divider for the EX stage: restoring radix-2, one quotient bit per cycle.
// Returns {remainder, quotient}, with the sign fixed up for DIV and a zero result on divide-by-zero.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall_req
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [64:0] rem_r;
    logic [31:0] divisor_r;
    logic        neg_quot_r;
    logic        neg_rem_r;
    logic [63:0] result_r;
    logic        ready_r;

    logic [31:0] abs1_s;
    logic [31:0] abs2_s;
    logic [64:0] shifted_s;
    logic [32:0] trial_s;
    logic [64:0] step_s;
    logic [31:0] quot_s;
    logic [31:0] remd_s;

    // Operand magnitudes captured on accept; 0x80000000 stays 0x80000000 as an unsigned magnitude.
    always_comb begin
        abs1_s = opdata1;
        abs2_s = opdata2;
        if (signed_div && opdata1[31]) begin
            abs1_s = 32'd0 - opdata1;
        end else begin
            abs1_s = opdata1;
        end
        if (signed_div && opdata2[31]) begin
            abs2_s = 32'd0 - opdata2;
        end else begin
            abs2_s = opdata2;
        end
    end

    // One restoring step; a set bit 32 of the 33-bit trial difference means it went negative.
    always_comb begin
        shifted_s = {rem_r[63:0], 1'b0};
        trial_s   = shifted_s[64:32] - {1'b0, divisor_r};
        step_s    = shifted_s;
        if (trial_s[32]) begin
            step_s = shifted_s;
        end else begin
            step_s = {trial_s, shifted_s[31:1], 1'b1};
        end
    end

    // Sign fixup applied to the final step so the result is ready on END entry.
    always_comb begin
        quot_s = step_s[31:0];
        remd_s = step_s[63:32];
        if (neg_quot_r) begin
            quot_s = 32'd0 - step_s[31:0];
        end else begin
            quot_s = step_s[31:0];
        end
        if (neg_rem_r) begin
            remd_s = 32'd0 - step_s[63:32];
        end else begin
            remd_s = step_s[63:32];
        end
    end

    // Control FSM with datapath registers and registered result/ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= 5'd0;
            rem_r      <= 65'd0;
            divisor_r  <= 32'd0;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            result_r   <= 64'd0;
            ready_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ready_r  <= 1'b0;
                    result_r <= 64'd0;
                    if (start && !annul) begin
                        divisor_r  <= abs2_s;
                        rem_r      <= {33'd0, abs1_s};
                        neg_quot_r <= signed_div & (opdata1[31] ^ opdata2[31]);
                        neg_rem_r  <= signed_div & opdata1[31];
                        cnt_r      <= 5'd0;
                        if (opdata2 == 32'd0) begin
                            state_r <= S_BYZERO;
                        end else begin
                            state_r <= S_ON;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_BYZERO: begin
                    if (annul || !start) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r  <= S_END;
                        result_r <= 64'd0;
                        ready_r  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul || !start) begin
                        state_r <= S_IDLE;
                        cnt_r   <= 5'd0;
                    end else begin
                        rem_r <= step_s;
                        cnt_r <= cnt_r + 5'd1;
                        if (cnt_r == 5'd31) begin
                            state_r  <= S_END;
                            result_r <= {remd_s, quot_s};
                            ready_r  <= 1'b1;
                        end else begin
                            state_r <= S_ON;
                        end
                    end
                end
                S_END: begin
                    if (annul || !start) begin
                        state_r  <= S_IDLE;
                        result_r <= 64'd0;
                        ready_r  <= 1'b0;
                    end else begin
                        state_r <= S_END;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    cnt_r    <= 5'd0;
                    result_r <= 64'd0;
                    ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign result    = result_r;
    assign ready     = ready_r;
    assign stall_req = start & ~ready_r;

endmodule
